// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants for the register-file writeback controller: datapath widths,
// requester count and the fixed requester slot assignments.
package regfile_wb_ctrl_pkg;

  localparam int unsigned WB_RFIDX_WIDTH = 5;
  localparam int unsigned WB_XLEN        = 32;

  localparam int unsigned WB_NREQ = 3;
  localparam int unsigned WB_ALU  = 0;
  localparam int unsigned WB_LSU  = 1;
  localparam int unsigned WB_MDU  = 2;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback request bus: NREQ sources each present valid/addr/data and receive
// a one-hot ready from the controller.
interface regfile_wb_ctrl_if #(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned RFIDX_WIDTH = 5,
  parameter int unsigned XLEN        = 32
);

  logic [NREQ-1:0]             wb_valid;
  logic [NREQ-1:0]             wb_ready;
  logic [NREQ*RFIDX_WIDTH-1:0] wb_addr;
  logic [NREQ*XLEN-1:0]        wb_data;

  modport master (
    output wb_valid,
    output wb_addr,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_addr,
    input  wb_data,
    output wb_ready
  );

endinterface

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer with wraparound;
// the pointer moves past the winner only when adv reports a completed handshake.
module rr_arbiter
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] win_idx;
  logic          found;

  // Grant search is kept apart from the pointer update so that adv, which is
  // derived from gnt, never feeds back into the grant logic.
  always_comb begin
    int unsigned sum;
    logic [PW-1:0] idx;
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      sum = 32'(ptr_q) + off;
      if (sum >= N) sum = sum - N;
      idx = PW'(sum);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt     = '0;
        gnt[idx] = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv && found) ptr_d = PW'(wrap_inc(32'(win_idx), N));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates NREQ sources onto the single regfile write
// port with one cycle of latency and tracks pending writes for hazard stalls.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int unsigned NREQ        = WB_NREQ,
  parameter int unsigned RFIDX_WIDTH = WB_RFIDX_WIDTH,
  parameter int unsigned XLEN        = WB_XLEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_wb_ctrl_if.slave       wb,
  output logic                   rf_write,
  output logic [RFIDX_WIDTH-1:0] rf_write_addr,
  output logic [XLEN-1:0]        rf_write_data,
  input  logic                   iss_valid,
  input  logic [RFIDX_WIDTH-1:0] iss_rd,
  input  logic [RFIDX_WIDTH-1:0] rs1_addr,
  input  logic [RFIDX_WIDTH-1:0] rs2_addr,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic                   rd_busy,
  input  logic                   flush
);

  localparam int unsigned NREGS = 1 << RFIDX_WIDTH;

  logic [NREQ-1:0]        arb_gnt;
  logic [NREQ-1:0]        gnt;
  logic                   hs;
  logic [RFIDX_WIDTH-1:0] sel_addr;
  logic [XLEN-1:0]        sel_data;

  logic                   rf_write_q, rf_write_d;
  logic [RFIDX_WIDTH-1:0] rf_write_addr_q, rf_write_addr_d;
  logic [XLEN-1:0]        rf_write_data_q, rf_write_data_d;
  logic [NREGS-1:0]       pending_q, pending_d;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wb.wb_valid),
    .adv   (hs),
    .gnt   (arb_gnt)
  );

  // No grant is offered while reset is asserted, even with requests pending.
  assign gnt         = arb_gnt & {NREQ{rst_n}};
  assign wb.wb_ready = gnt;
  assign hs          = |(wb.wb_valid & gnt);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = wb.wb_addr[i*RFIDX_WIDTH +: RFIDX_WIDTH];
        sel_data = wb.wb_data[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writes are consumed by the handshake but never reach the regfile.
  always_comb begin
    rf_write_d      = hs && (sel_addr != '0);
    rf_write_addr_d = rf_write_addr_q;
    rf_write_data_d = rf_write_data_q;
    if (hs) begin
      rf_write_addr_d = sel_addr;
      rf_write_data_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_q      <= 1'b0;
      rf_write_addr_q <= '0;
      rf_write_data_q <= '0;
    end else begin
      rf_write_q      <= rf_write_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_write_data_q <= rf_write_data_d;
    end
  end

  assign rf_write      = rf_write_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_write_data = rf_write_data_q;

  // Clear on the commit edge, then set from issue so a same-edge set wins;
  // flush overrides both.
  always_comb begin
    pending_d = pending_q;
    if (rf_write_q) pending_d[rf_write_addr_q] = 1'b0;
    if (iss_valid && (iss_rd != '0)) pending_d[iss_rd] = 1'b1;
    if (flush) pending_d = '0;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign rs1_busy = (rs1_addr != '0) && pending_q[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) && pending_q[rs2_addr];
  assign rd_busy  = (iss_rd   != '0) && pending_q[iss_rd];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized scoreboard bench for regfile_wb_ctrl with a behavioural model of
// round-robin grants, one-cycle writeback and the pending-write table.
module tb_regfile_wb_ctrl;
  import regfile_wb_ctrl_pkg::*;

  localparam int N  = WB_NREQ;
  localparam int AW = WB_RFIDX_WIDTH;
  localparam int DW = WB_XLEN;
  localparam int NR = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if #(.NREQ(N), .RFIDX_WIDTH(AW), .XLEN(DW)) wbif ();

  logic          rf_write;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_write_data;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_rd = '0;
  logic [AW-1:0] rs1_addr = '0;
  logic [AW-1:0] rs2_addr = '0;
  logic          rs1_busy, rs2_busy, rd_busy;
  logic          flush = 1'b0;

  regfile_wb_ctrl #(.NREQ(N), .RFIDX_WIDTH(AW), .XLEN(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb            (wbif),
    .rf_write      (rf_write),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .iss_valid     (iss_valid),
    .iss_rd        (iss_rd),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rd_busy       (rd_busy),
    .flush         (flush)
  );

  // Stand-in regfile fed by the DUT write port.
  logic [DW-1:0] rf_mem [NR];
  always @(posedge clk) if (rf_write) rf_mem[rf_write_addr] <= rf_write_data;

  int checks = 0;
  int errors = 0;

  // Requester state and reference model state.
  bit            req_act [N];
  logic [AW-1:0] req_a   [N];
  logic [DW-1:0] req_d   [N];
  int            m_ptr   = 0;
  bit            m_pend  [NR];
  bit            m_out_v = 1'b0;
  logic [AW-1:0] m_out_a = '0;
  int            last_g  = -1;
  int            cyc     = 0;

  typedef struct {
    logic [N-1:0] gnt;
    bit           b1, b2, bd;
  } cyc_exp_t;
  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_exp_t;
  cyc_exp_t cq[$];
  wr_exp_t  wq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_grant();
    for (int off = 0; off < N; off++) begin
      int j;
      j = (m_ptr + off) % N;
      if (req_act[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      wbif.wb_valid[i]           = req_act[i];
      wbif.wb_addr[i*AW +: AW]   = req_a[i];
      wbif.wb_data[i*DW +: DW]   = req_d[i];
    end
  endtask

  // Advance the model across the clock edge just taken, then clear one-shot inputs.
  task automatic tick_begin();
    @(posedge clk);
    #1;
    cyc++;
    if (m_out_v) m_pend[m_out_a] = 1'b0;
    if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    if (flush) foreach (m_pend[k]) m_pend[k] = 1'b0;
    m_out_v = 1'b0;
    if (last_g >= 0) begin
      m_out_v = (req_a[last_g] != 0);
      m_out_a = req_a[last_g];
      m_ptr   = (last_g + 1) % N;
      req_act[last_g] = 1'b0;
    end
    iss_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Apply this cycle's inputs and record what the DUT must show.
  task automatic tick_end();
    cyc_exp_t e;
    int g;
    drive_inputs();
    g = model_grant();
    e.gnt = '0;
    if (g >= 0) e.gnt[g] = 1'b1;
    e.b1 = (rs1_addr != 0) && m_pend[rs1_addr];
    e.b2 = (rs2_addr != 0) && m_pend[rs2_addr];
    e.bd = (iss_rd   != 0) && m_pend[iss_rd];
    cq.push_back(e);
    if (g >= 0 && req_a[g] != 0) wq.push_back('{cyc: cyc, a: req_a[g], d: req_d[g]});
    last_g = g;
  endtask

  task automatic arm(input int i, input int a, input logic [DW-1:0] d);
    req_act[i] = 1'b1;
    req_a[i]   = AW'(a);
    req_d[i]   = d;
  endtask

  // Monitor: compares DUT outputs against queued expectations each cycle.
  initial begin
    cyc_exp_t e;
    wr_exp_t  w;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        e = cq.pop_front();
        check("wb_ready", 64'(wbif.wb_ready), 64'(e.gnt));
        check("rs1_busy", 64'(rs1_busy), 64'(e.b1));
        check("rs2_busy", 64'(rs2_busy), 64'(e.b2));
        check("rd_busy",  64'(rd_busy),  64'(e.bd));
        if (rf_write) begin
          if (wq.size() == 0) begin
            check("unexpected_rf_write", 64'(rf_write), 64'd0);
          end else begin
            w = wq.pop_front();
            check("rf_write_latency", 64'(cyc), 64'(w.cyc + 1));
            check("rf_write_addr", 64'(rf_write_addr), 64'(w.a));
            check("rf_write_data", 64'(rf_write_data), 64'(w.d));
          end
        end else if (wq.size() > 0 && wq[0].cyc + 1 <= cyc) begin
          w = wq.pop_front();
          check("missing_rf_write", 64'(rf_write), 64'd1);
        end
      end
    end
  end

  initial begin
    // Reset with every requester asserting valid.
    for (int i = 0; i < N; i++) arm(i, i + 1, $urandom);
    drive_inputs();
    rs1_addr = 5'd1; rs2_addr = 5'd2; iss_rd = 5'd3;
    #13;
    check("reset_wb_ready", 64'(wbif.wb_ready), 64'd0);
    check("reset_rf_write", 64'(rf_write), 64'd0);
    check("reset_rf_write_addr", 64'(rf_write_addr), 64'd0);
    check("reset_rf_write_data", 64'(rf_write_data), 64'd0);
    check("reset_busy", 64'({rs1_busy, rs2_busy, rd_busy}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick_end();

    // Contention: all three valid with addrs 1/2/3 for six cycles.
    for (int c = 0; c < 5; c++) begin
      tick_begin();
      for (int i = 0; i < N; i++) arm(i, i + 1, $urandom);
      tick_end();
    end
    for (int c = 0; c < 3; c++) begin tick_begin(); tick_end(); end

    // Pending x5 until LSU writes 0xDEADBEEF.
    tick_begin(); iss_valid = 1'b1; iss_rd = 5'd5; rs1_addr = 5'd5; tick_end();
    for (int c = 0; c < 2; c++) begin tick_begin(); iss_rd = 5'd0; tick_end(); end
    tick_begin(); arm(WB_LSU, 5, 32'hDEADBEEF); tick_end();
    for (int c = 0; c < 3; c++) begin tick_begin(); tick_end(); end
    check("regfile_x5", 64'(rf_mem[5]), 64'h0000_0000_DEAD_BEEF);

    // Commit of x7 on the same edge that re-issues x7.
    tick_begin(); arm(WB_MDU, 7, $urandom); rs1_addr = 5'd7; tick_end();
    tick_begin(); iss_valid = 1'b1; iss_rd = 5'd7; tick_end();
    tick_begin(); iss_rd = 5'd0; tick_end();
    tick_begin(); arm(WB_MDU, 7, 32'h0000_7777); tick_end();
    for (int c = 0; c < 2; c++) begin tick_begin(); tick_end(); end

    // x0 write, then flush with x4 in flight.
    tick_begin(); arm(WB_ALU, 0, 32'h1234_5678); iss_valid = 1'b1; iss_rd = 5'd4; tick_end();
    tick_begin(); arm(WB_ALU, 4, 32'h0000_4444); iss_valid = 1'b1; iss_rd = 5'd9; tick_end();
    tick_begin(); flush = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd9; iss_rd = 5'd0; tick_end();
    tick_begin(); tick_end();
    tick_begin(); tick_end();
    check("regfile_x4", 64'(rf_mem[4]), 64'h4444);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      int rd;
      tick_begin();
      for (int i = 0; i < N; i++)
        if (!req_act[i] && $urandom_range(0, 2) == 0)
          arm(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, NR - 1), $urandom);
      rd = $urandom_range(0, NR - 1);
      iss_rd = AW'(rd);
      if ($urandom_range(0, 2) == 0 && !m_pend[rd]) iss_valid = 1'b1;
      flush    = ($urandom_range(0, 63) == 0);
      rs1_addr = AW'($urandom_range(0, NR - 1));
      rs2_addr = AW'($urandom_range(0, NR - 1));
      tick_end();
    end

    // Drain outstanding requests.
    for (int c = 0; c < 8; c++) begin tick_begin(); tick_end(); end
    @(negedge clk);
    #1;
    check("writes_drained", 64'(wq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
